preamble_detector: RTL

Receive-side counterpart of the preamble generator: consumes the real (I) sample stream, detects the repetitive short-training preamble by delay-and-correlate against its own period, and marks the frame boundary. Emits a detect pulse at plateau lock, a start-of-payload pulse when the plateau ends, and an end-of-frame pulse after a fixed payload length. The input stream is forwarded with fixed latency so downstream blocks see markers aligned to samples.

---
 rtl/preamble_detector_if.sv | 23 ++
 rtl/preamble_detector.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/preamble_detector_if.sv
// Sample-stream bus for the preamble detector.
// Master drives samples in; slave returns the delayed stream and frame markers.
interface preamble_detector_if;
    logic               enable;
    logic               valid_in;
    logic signed [15:0] in_i;
    logic signed [15:0] out_i;
    logic               valid_out;
    logic               detect;
    logic               sop;
    logic               eop;
    logic               busy;

    modport master (
        output enable, valid_in, in_i,
        input  out_i, valid_out, detect, sop, eop, busy
    );

    modport slave (
        input  enable, valid_in, in_i,
        output out_i, valid_out, detect, sop, eop, busy
    );
endinterface

// File: rtl/preamble_detector.sv
// Delay-and-correlate short-preamble detector with frame boundary markers.
// Three-stage pipeline: capture, multiply, accumulate/decide.
module preamble_detector #(
    parameter int P          = 16,
    parameter int W          = 16,
    parameter int HOLD       = 32,
    parameter int FRAME_LEN  = 64,
    parameter int MIN_ENERGY = 1024
) (
    input  logic              clock,
    input  logic              reset,
    preamble_detector_if.slave bus
);
    localparam int SW = $clog2(P + W) + 1;
    localparam int CW = $clog2(HOLD + 1);
    localparam int DW = $clog2(FRAME_LEN + 1);

    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_COUNT  = 2'd1;
    localparam logic [1:0] S_LOCK   = 2'd2;
    localparam logic [1:0] S_DATA   = 2'd3;

    logic signed [15:0] r_xdl [P];
    logic               r_v1;
    logic signed [15:0] r_x1;
    logic signed [15:0] r_xd1;

    logic               r_v2;
    logic signed [15:0] r_x2;
    logic signed [31:0] r_prod;
    logic        [31:0] r_pwr;

    logic signed [31:0] r_pdl [W];
    logic        [31:0] r_edl [W];
    logic signed [36:0] r_corr;
    logic        [35:0] r_energy;
    logic      [SW-1:0] r_nseen;
    logic         [1:0] r_state;
    logic      [CW-1:0] r_cnt;
    logic      [DW-1:0] r_dcnt;
    logic               r_v3;
    logic signed [15:0] r_out;
    logic               r_det;
    logic               r_sop;
    logic               r_eop;
    logic               r_busy;

    logic signed [31:0] w_prod;
    logic signed [31:0] w_sq;
    logic signed [36:0] w_corr;
    logic        [35:0] w_energy;
    logic signed [39:0] w_lhs;
    logic signed [39:0] w_rhs;
    logic               w_warm;
    logic               w_cond;
    logic         [1:0] w_state_n;
    logic      [CW-1:0] w_cnt_n;
    logic      [DW-1:0] w_dcnt_n;
    logic               w_det;
    logic               w_sop;
    logic               w_eop;
    logic               w_busy_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < P; k++) r_xdl[k] <= '0;
            r_v1  <= 1'b0;
            r_x1  <= '0;
            r_xd1 <= '0;
        end else if (bus.enable) begin
            r_v1 <= bus.valid_in;
            if (bus.valid_in) begin
                r_x1  <= bus.in_i;
                r_xd1 <= r_xdl[P-1];
                for (int k = P - 1; k > 0; k--) r_xdl[k] <= r_xdl[k-1];
                r_xdl[0] <= bus.in_i;
            end
        end
    end

    assign w_prod = r_x1 * r_xd1;
    assign w_sq   = r_x1 * r_x1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_v2   <= 1'b0;
            r_x2   <= '0;
            r_prod <= '0;
            r_pwr  <= '0;
        end else if (bus.enable) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_x2   <= r_x1;
                r_prod <= w_prod;
                r_pwr  <= $unsigned(w_sq);
            end
        end
    end

    // Running window sums: add newest, drop the one leaving the window.
    assign w_corr   = r_corr + 37'(r_prod) - 37'(r_pdl[W-1]);
    assign w_energy = r_energy + 36'(r_pwr) - 36'(r_edl[W-1]);
    assign w_lhs    = 40'(w_corr) * 40'sd4;
    assign w_rhs    = $signed({4'b0, w_energy}) * 40'sd3;
    assign w_warm   = r_nseen >= SW'(P + W - 1);
    assign w_cond   = w_warm && (w_energy >= 36'(MIN_ENERGY)) && (w_lhs > w_rhs);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_dcnt_n  = r_dcnt;
        w_det     = 1'b0;
        w_sop     = 1'b0;
        w_eop     = 1'b0;
        unique case (r_state)
            S_SEARCH, S_COUNT: begin
                if (!w_cond) begin
                    w_state_n = S_SEARCH;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n   = (r_state == S_SEARCH) ? CW'(1) : r_cnt + CW'(1);
                    w_state_n = S_COUNT;
                    if (w_cnt_n == CW'(HOLD)) begin
                        w_det     = 1'b1;
                        w_state_n = S_LOCK;
                    end
                end
            end
            S_LOCK: begin
                if (!w_cond) begin
                    w_sop     = 1'b1;
                    w_dcnt_n  = DW'(1);
                    w_state_n = S_DATA;
                    if (FRAME_LEN == 1) begin
                        w_eop     = 1'b1;
                        w_state_n = S_SEARCH;
                        w_cnt_n   = '0;
                    end
                end
            end
            default: begin
                w_dcnt_n = r_dcnt + DW'(1);
                if (w_dcnt_n == DW'(FRAME_LEN)) begin
                    w_eop     = 1'b1;
                    w_state_n = S_SEARCH;
                    w_cnt_n   = '0;
                end
            end
        endcase
    end

    // Busy covers the eop sample itself even though the FSM leaves DATA there.
    assign w_busy_n = (w_state_n == S_LOCK) || (w_state_n == S_DATA) || w_eop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < W; k++) begin
                r_pdl[k] <= '0;
                r_edl[k] <= '0;
            end
            r_corr   <= '0;
            r_energy <= '0;
            r_nseen  <= '0;
            r_state  <= S_SEARCH;
            r_cnt    <= '0;
            r_dcnt   <= '0;
            r_v3     <= 1'b0;
            r_out    <= '0;
            r_det    <= 1'b0;
            r_sop    <= 1'b0;
            r_eop    <= 1'b0;
            r_busy   <= 1'b0;
        end else if (bus.enable) begin
            r_v3  <= r_v2;
            r_det <= r_v2 & w_det;
            r_sop <= r_v2 & w_sop;
            r_eop <= r_v2 & w_eop;
            if (r_v2) begin
                for (int k = W - 1; k > 0; k--) begin
                    r_pdl[k] <= r_pdl[k-1];
                    r_edl[k] <= r_edl[k-1];
                end
                r_pdl[0] <= r_prod;
                r_edl[0] <= r_pwr;
                r_corr   <= w_corr;
                r_energy <= w_energy;
                if (!w_warm) r_nseen <= r_nseen + SW'(1);
                r_state  <= w_state_n;
                r_cnt    <= w_cnt_n;
                r_dcnt   <= w_dcnt_n;
                r_out    <= r_x2;
                r_busy   <= w_busy_n;
            end
        end
    end

    assign bus.out_i     = r_out;
    assign bus.busy      = r_busy;
    assign bus.valid_out = r_v3 & bus.enable;
    assign bus.detect    = r_det & bus.enable;
    assign bus.sop       = r_sop & bus.enable;
    assign bus.eop       = r_eop & bus.enable;
endmodule
